// File: rtl/bullet_pkg.sv
// Shared types and constants for the bullet scheduler slice.
package bullet_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRE     = 2'd1,
    COOLDOWN = 2'd2
  } sched_state_t;

  localparam logic [2:0] DIR_LEFT  = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd3;

  localparam int N_SLOTS_DEFAULT = 4;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one registered delay of a level input, then AND-NOT.
// The pulse is combinational, valid in the cycle the input is first seen high.
module rise_detect (
  input  logic Clk,
  input  logic Reset_n,
  input  logic sig,
  output logic rise
);

  logic sig_d_r;

  // Delay the level by one Clk so a new high level can be told from an old one
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sig_d_r <= 1'b0;
    end else begin
      sig_d_r <= sig;
    end
  end

  assign rise = sig & ~sig_d_r;

endmodule

// File: rtl/bullet_scheduler.sv
// Bullet scheduler: turns shoot key edges into single fire pulses to the lowest
// free bullet slot, gated by a frame-counted cooldown and an ammo budget, and
// routes the global monster-hit flag back to the slot owning the pixel.
module bullet_scheduler
  import bullet_pkg::*;
#(
  parameter int N_SLOTS         = N_SLOTS_DEFAULT,
  parameter int COOLDOWN_FRAMES = 6,
  parameter int AMMO_MAX        = 15,
  parameter int AMMO_W          = 4
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               enable,
  input  logic               frame_clk,
  input  logic               shoot,
  input  logic [2:0]         direction,
  input  logic               refill,
  input  logic [N_SLOTS-1:0] fly,
  input  logic [N_SLOTS-1:0] is_bullet,
  input  logic               hit,
  output logic [N_SLOTS-1:0] slot_shoot,
  output logic [N_SLOTS-1:0] slot_hit,
  output logic [2:0]         fire_dir,
  output logic [AMMO_W-1:0]  ammo,
  output logic               ammo_empty,
  output logic               cooldown,
  output logic [7:0]         shots_fired
);

  localparam int                CNT_W     = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [AMMO_W-1:0] AMMO_FULL = AMMO_W'(AMMO_MAX);

  // One-hot of the lowest set bit; all zero when nothing is set.
  function automatic logic [N_SLOTS-1:0] lowest_one(input logic [N_SLOTS-1:0] v);
    logic [N_SLOTS-1:0] r;
    logic               found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      r[i]  = v[i] & ~found;
      found = found | v[i];
    end
    return r;
  endfunction

  logic               shoot_edge_s;
  logic               frame_edge_s;
  logic [N_SLOTS-1:0] free_s;
  logic [N_SLOTS-1:0] sel_s;
  logic               any_free_s;
  logic               capture_s;
  logic               fire_now_s;

  sched_state_t       state_r;
  sched_state_t       state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic [N_SLOTS-1:0] sel_q_r;
  logic [2:0]         fire_dir_r;
  logic [N_SLOTS-1:0] slot_shoot_r;
  logic [N_SLOTS-1:0] slot_hit_r;
  logic [AMMO_W-1:0]  ammo_r;
  logic [7:0]         shots_r;

  rise_detect u_shoot_rise (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .sig     (shoot),
    .rise    (shoot_edge_s)
  );

  rise_detect u_frame_rise (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .sig     (frame_clk),
    .rise    (frame_edge_s)
  );

  assign free_s     = ~fly;
  assign sel_s      = lowest_one(free_s);
  assign any_free_s = |free_s;
  // The fire cycle only takes effect while the game is running.
  assign fire_now_s = enable && (state_r == FIRE);

  // Next-state and cooldown counter; enable low aborts to IDLE from anywhere
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    capture_s   = 1'b0;
    if (!enable) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (shoot_edge_s && any_free_s && (ammo_r != '0)) begin
            state_nxt_s = FIRE;
            capture_s   = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        FIRE: begin
          state_nxt_s = COOLDOWN;
          cnt_nxt_s   = '0;
        end
        COOLDOWN: begin
          if (frame_edge_s) begin
            if (cnt_r == CNT_LAST) begin
              state_nxt_s = IDLE;
              cnt_nxt_s   = '0;
            end else begin
              cnt_nxt_s = cnt_r + CNT_W'(1);
            end
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end
      endcase
    end
  end

  // State and cooldown counter registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Freeze the chosen slot and facing at the IDLE decision so late fly changes cannot redirect the shot
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sel_q_r    <= '0;
      fire_dir_r <= 3'd0;
    end else if (capture_s) begin
      sel_q_r    <= sel_s;
      fire_dir_r <= direction;
    end else begin
      sel_q_r    <= sel_q_r;
      fire_dir_r <= fire_dir_r;
    end
  end

  // One-cycle fire pulse, ammo spend and shot count, all committed by the FIRE cycle
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      slot_shoot_r <= '0;
      ammo_r       <= AMMO_FULL;
      shots_r      <= 8'd0;
    end else begin
      slot_shoot_r <= fire_now_s ? sel_q_r : '0;
      if (refill) begin
        ammo_r <= AMMO_FULL;
      end else if (fire_now_s && (ammo_r != '0)) begin
        ammo_r <= ammo_r - AMMO_W'(1);
      end else begin
        ammo_r <= ammo_r;
      end
      if (fire_now_s && (shots_r != 8'hFF)) begin
        shots_r <= shots_r + 8'd1;
      end else begin
        shots_r <= shots_r;
      end
    end
  end

  // Hit routing runs every cycle regardless of FSM state or enable
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      slot_hit_r <= '0;
    end else begin
      slot_hit_r <= is_bullet & {N_SLOTS{hit}};
    end
  end

  assign slot_shoot  = slot_shoot_r;
  assign slot_hit    = slot_hit_r;
  assign fire_dir    = fire_dir_r;
  assign ammo        = ammo_r;
  assign ammo_empty  = (ammo_r == '0);
  assign cooldown    = (state_r == COOLDOWN);
  assign shots_fired = shots_r;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler with a scoreboard of expected fire events.
module tb_bullet_scheduler;
  import bullet_pkg::*;

  logic       Clk;
  logic       Reset_n;
  logic       enable;
  logic       frame_clk;
  logic       shoot;
  logic [2:0] direction;
  logic       refill;
  logic [3:0] fly;
  logic [3:0] is_bullet;
  logic       hit;
  logic [3:0] slot_shoot;
  logic [3:0] slot_hit;
  logic [2:0] fire_dir;
  logic [3:0] ammo;
  logic       ammo_empty;
  logic       cooldown;
  logic [7:0] shots_fired;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] slot;
    logic [3:0] ammo;
    logic [7:0] shots;
    logic [2:0] dir;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_ammo;
  logic [7:0] m_shots;

  bullet_scheduler dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .enable      (enable),
    .frame_clk   (frame_clk),
    .shoot       (shoot),
    .direction   (direction),
    .refill      (refill),
    .fly         (fly),
    .is_bullet   (is_bullet),
    .hit         (hit),
    .slot_shoot  (slot_shoot),
    .slot_hit    (slot_hit),
    .fire_dir    (fire_dir),
    .ammo        (ammo),
    .ammo_empty  (ammo_empty),
    .cooldown    (cooldown),
    .shots_fired (shots_fired)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a shoot edge and expect a fire pulse to exp_slot two cycles later.
  task automatic fire_expect(input string tag, input logic [3:0] exp_slot,
                             input logic [3:0] late_fly, input logic late_refill);
    exp_t e;
    exp_t got;
    logic seen;
    int   lat;
    e.slot  = exp_slot;
    e.ammo  = late_refill ? 4'd15 : (m_ammo - 4'd1);
    e.shots = (m_shots == 8'hFF) ? 8'hFF : (m_shots + 8'd1);
    e.dir   = direction;
    sb.push_back(e);
    shoot = 1'b1;
    seen  = 1'b0;
    lat   = 0;
    for (int c = 1; c <= 4 && !seen; c++) begin
      tick();
      if (c == 1) begin
        fly    = late_fly;
        refill = late_refill;
      end else begin
        refill = 1'b0;
      end
      if (slot_shoot != 4'd0) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    refill = 1'b0;
    got = sb.pop_front();
    chk({tag, "_slot"}, slot_shoot, got.slot);
    chk({tag, "_latency"}, lat, 2);
    chk({tag, "_ammo"}, ammo, got.ammo);
    chk({tag, "_shots"}, shots_fired, got.shots);
    chk({tag, "_dir"}, fire_dir, got.dir);
    chk({tag, "_cooldown"}, cooldown, 1'b1);
    m_ammo  = got.ammo;
    m_shots = got.shots;
    shoot   = 1'b0;
    tick();
    chk({tag, "_width"}, slot_shoot, 4'd0);
  endtask

  // One frame_clk rising edge.
  task automatic frame_pulse();
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
    tick();
  endtask

  // Let the full cooldown elapse and confirm the return to IDLE.
  task automatic cool(input string tag);
    repeat (6) frame_pulse();
    chk({tag, "_cool_done"}, cooldown, 1'b0);
  endtask

  // Shoot edge that must not fire; ammo must hold.
  task automatic no_fire(input string tag);
    logic [3:0] acc;
    acc   = 4'd0;
    shoot = 1'b1;
    repeat (3) begin
      tick();
      acc |= slot_shoot;
    end
    shoot = 1'b0;
    tick();
    acc |= slot_shoot;
    chk({tag, "_pulse"}, acc, 4'd0);
    chk({tag, "_ammo"}, ammo, m_ammo);
  endtask

  initial begin
    logic [3:0] acc;
    Reset_n   = 1'b0;
    enable    = 1'b1;
    frame_clk = 1'b0;
    shoot     = 1'b0;
    direction = 3'd0;
    refill    = 1'b0;
    fly       = 4'd0;
    is_bullet = 4'd0;
    hit       = 1'b0;
    m_ammo    = 4'd15;
    m_shots   = 8'd0;

    // Reset state
    tick();
    tick();
    chk("rst_slot_shoot", slot_shoot, 4'd0);
    chk("rst_slot_hit", slot_hit, 4'd0);
    chk("rst_fire_dir", fire_dir, 3'd0);
    chk("rst_ammo", ammo, 4'd15);
    chk("rst_ammo_empty", ammo_empty, 1'b0);
    chk("rst_cooldown", cooldown, 1'b0);
    chk("rst_shots", shots_fired, 8'd0);
    Reset_n = 1'b1;
    repeat (8) tick();

    // First shot to slot 0, facing right
    direction = DIR_RIGHT;
    fire_expect("shot1", 4'b0001, 4'b0000, 1'b0);

    // Shoot edges after frame edges 1..5 are dropped; the 6th ends cooldown
    for (int f = 0; f < 5; f++) begin
      frame_pulse();
      acc   = 4'd0;
      shoot = 1'b1;
      tick();
      acc |= slot_shoot;
      tick();
      acc |= slot_shoot;
      shoot = 1'b0;
      tick();
      acc |= slot_shoot;
      chk($sformatf("cd_drop%0d", f), acc, 4'd0);
      chk($sformatf("cd_hold%0d", f), cooldown, 1'b1);
    end
    frame_pulse();
    chk("cd_exit", cooldown, 1'b0);
    fire_expect("after_cd", 4'b0001, 4'b0000, 1'b0);
    cool("after_cd");

    // Lowest free slot selection
    fly       = 4'b0011;
    direction = DIR_LEFT;
    fire_expect("sel2", 4'b0100, 4'b0011, 1'b0);
    cool("sel2");
    fly = 4'b1111;
    no_fire("all_busy");
    fly = 4'b0000;

    // Slot becoming busy right after selection still gets the pulse
    direction = 3'd2;
    fire_expect("late_fly", 4'b0001, 4'b0001, 1'b0);
    fly = 4'b0000;
    cool("late_fly");

    // Drain the ammo budget
    while (m_ammo != 4'd0) begin
      fire_expect("drain", 4'b0001, 4'b0000, 1'b0);
      cool("drain");
    end
    chk("empty_ammo", ammo, 4'd0);
    chk("empty_flag", ammo_empty, 1'b1);
    no_fire("empty");

    // Standalone refill, then refill colliding with the FIRE decrement
    refill = 1'b1;
    tick();
    refill = 1'b0;
    m_ammo = 4'd15;
    chk("refill_ammo", ammo, 4'd15);
    chk("refill_flag", ammo_empty, 1'b0);
    fire_expect("refill_fire", 4'b0001, 4'b0000, 1'b1);
    cool("refill_fire");

    // Hit routing
    hit       = 1'b1;
    is_bullet = 4'b0110;
    tick();
    chk("hit_route", slot_hit, 4'b0110);
    hit = 1'b0;
    tick();
    chk("hit_clear", slot_hit, 4'd0);

    // Hit routing with the game stopped, and no fire while stopped
    enable    = 1'b0;
    hit       = 1'b1;
    is_bullet = 4'b1001;
    tick();
    chk("hit_disabled", slot_hit, 4'b1001);
    hit       = 1'b0;
    is_bullet = 4'd0;
    no_fire("disabled");
    enable = 1'b1;
    tick();

    // enable low during cooldown returns to IDLE next cycle; ammo held
    fire_expect("en_abort", 4'b0001, 4'b0000, 1'b0);
    enable = 1'b0;
    tick();
    chk("en_abort_idle", cooldown, 1'b0);
    chk("en_abort_ammo", ammo, m_ammo);
    chk("en_abort_shots", shots_fired, m_shots);
    enable = 1'b1;
    tick();
    fire_expect("en_refire", 4'b0001, 4'b0000, 1'b0);

    // Asynchronous reset in cooldown, no Clk edge in between
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_cooldown", cooldown, 1'b0);
    chk("arst_ammo", ammo, 4'd15);
    chk("arst_shots", shots_fired, 8'd0);
    chk("arst_slot_shoot", slot_shoot, 4'd0);
    tick();
    Reset_n = 1'b1;
    m_ammo  = 4'd15;
    m_shots = 8'd0;
    tick();
    fire_expect("post_rst", 4'b0001, 4'b0000, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
